rename_regfile_mp: RTL and testbench

- Architectural register file with a per-register rename tag (ROB tag) and valid bit.
- Generalises the single-lane renaming register file to:
  - parametrised register count and data width;
  - multiple rename (dispatch) lanes;
  - multiple commit lanes;
  - multiple operand read ports with commit bypass;
  - a registered busy-register count for dispatch and flush monitoring.
- Sits between the dispatch/rename stage, the ROB commit port and the reservation stations.

---
 rtl/rename_regfile_mp_if.sv | 37 +++
 rtl/rename_regfile_mp.sv | 146 ++++++++++++++
 tb/tb_rename_regfile_mp.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rename_regfile_mp_if.sv
// rtl/rename_regfile_mp_if.sv - rename/commit/operand-read bus for the multi-port rename register file
interface rename_regfile_mp_if #(
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  parameter int ROB_DEPTH = 16,
  parameter int REN_LANES = 2,
  parameter int CMT_LANES = 2,
  parameter int RD_PORTS  = 4,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int IDX_W     = $clog2(NUM_REGS)
) ();
  logic                          flush;
  logic [REN_LANES-1:0]          rename_en;
  logic [REN_LANES*IDX_W-1:0]    rename_rd;
  logic [REN_LANES*TAG_W-1:0]    rename_tag;
  logic [CMT_LANES-1:0]          commit_en;
  logic [CMT_LANES*IDX_W-1:0]    commit_rd;
  logic [CMT_LANES*DATA_W-1:0]   commit_val;
  logic [CMT_LANES*TAG_W-1:0]    commit_tag;
  logic [RD_PORTS*IDX_W-1:0]     rs_idx;
  logic [RD_PORTS-1:0]           rs_valid;
  logic [RD_PORTS*DATA_W-1:0]    rs_data;
  logic [RD_PORTS*TAG_W-1:0]     rs_tag;
  logic [IDX_W:0]                busy_cnt;

  modport master (
    output flush, rename_en, rename_rd, rename_tag,
    output commit_en, commit_rd, commit_val, commit_tag, rs_idx,
    input  rs_valid, rs_data, rs_tag, busy_cnt
  );

  modport slave (
    input  flush, rename_en, rename_rd, rename_tag,
    input  commit_en, commit_rd, commit_val, commit_tag, rs_idx,
    output rs_valid, rs_data, rs_tag, busy_cnt
  );
endinterface

// File: rtl/rename_regfile_mp.sv
// rtl/rename_regfile_mp.sv - architectural register file with ROB rename tags, multi-lane rename/commit and bypassed reads
module rename_regfile_mp #(
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  parameter int ROB_DEPTH = 16,
  parameter int REN_LANES = 2,
  parameter int CMT_LANES = 2,
  parameter int RD_PORTS  = 4,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  rename_regfile_mp_if.slave bus
);

  logic              valid_q [NUM_REGS];
  logic [DATA_W-1:0] data_q  [NUM_REGS];
  logic [TAG_W-1:0]  tag_q   [NUM_REGS];
  logic [IDX_W:0]    busy_q;

  logic              valid_n [NUM_REGS];
  logic [DATA_W-1:0] data_n  [NUM_REGS];
  logic [TAG_W-1:0]  tag_n   [NUM_REGS];
  logic [IDX_W:0]    busy_n;

  logic              ren_hit;
  logic [TAG_W-1:0]  ren_tag;
  logic              cmt_hit;
  logic              cmt_match;
  logic [DATA_W-1:0] cmt_val;

  // Lanes are scanned oldest to youngest so the youngest hit overrides.
  always_comb begin
    busy_n  = '0;
    ren_hit = 1'b0;
    ren_tag = '0;
    cmt_hit = 1'b0;
    cmt_match = 1'b0;
    cmt_val = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      valid_n[r] = valid_q[r];
      data_n[r]  = data_q[r];
      tag_n[r]   = tag_q[r];
    end
    valid_n[0] = 1'b1;
    data_n[0]  = '0;
    tag_n[0]   = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      ren_hit   = 1'b0;
      ren_tag   = '0;
      cmt_hit   = 1'b0;
      cmt_match = 1'b0;
      cmt_val   = '0;
      for (int i = 0; i < REN_LANES; i++) begin
        if (bus.rename_en[i] && bus.rename_rd[i*IDX_W +: IDX_W] == IDX_W'(r)) begin
          ren_hit = 1'b1;
          ren_tag = bus.rename_tag[i*TAG_W +: TAG_W];
        end
      end
      for (int j = 0; j < CMT_LANES; j++) begin
        if (bus.commit_en[j] && bus.commit_rd[j*IDX_W +: IDX_W] == IDX_W'(r)) begin
          cmt_hit = 1'b1;
          cmt_val = bus.commit_val[j*DATA_W +: DATA_W];
          if (bus.commit_tag[j*TAG_W +: TAG_W] == tag_q[r]) begin
            cmt_match = 1'b1;
          end
        end
      end
      if (rst) begin
        valid_n[r] = 1'b1;
        data_n[r]  = '0;
        tag_n[r]   = '0;
      end else begin
        if (cmt_hit) begin
          data_n[r] = cmt_val;
        end
        if (bus.flush) begin
          valid_n[r] = 1'b1;
          tag_n[r]   = '0;
        end else if (ren_hit) begin
          valid_n[r] = 1'b0;
          tag_n[r]   = ren_tag;
        end else if (cmt_match) begin
          valid_n[r] = 1'b1;
        end
      end
      busy_n = busy_n + (IDX_W+1)'(!valid_n[r]);
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      valid_q[r] <= valid_n[r];
      data_q[r]  <= data_n[r];
      tag_q[r]   <= tag_n[r];
    end
    busy_q <= busy_n;
  end

  logic [RD_PORTS-1:0]        rs_valid_c;
  logic [RD_PORTS*DATA_W-1:0] rs_data_c;
  logic [RD_PORTS*TAG_W-1:0]  rs_tag_c;
  logic [IDX_W-1:0]           ridx;
  logic                       rv;
  logic [DATA_W-1:0]          rdat;
  logic [TAG_W-1:0]           rtag;

  // Commits whose tag matches the stored producer are forwarded; same-cycle renames are not.
  always_comb begin
    rs_valid_c = '0;
    rs_data_c  = '0;
    rs_tag_c   = '0;
    ridx = '0;
    rv   = 1'b1;
    rdat = '0;
    rtag = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      ridx = bus.rs_idx[p*IDX_W +: IDX_W];
      rv   = valid_q[ridx];
      rdat = data_q[ridx];
      rtag = tag_q[ridx];
      for (int j = 0; j < CMT_LANES; j++) begin
        if (bus.commit_en[j] && bus.commit_rd[j*IDX_W +: IDX_W] == ridx &&
            bus.commit_tag[j*TAG_W +: TAG_W] == tag_q[ridx]) begin
          rv   = 1'b1;
          rdat = bus.commit_val[j*DATA_W +: DATA_W];
        end
      end
      if (rst || ridx == '0) begin
        rv   = 1'b1;
        rdat = '0;
        rtag = '0;
      end
      rs_valid_c[p]                = rv;
      rs_data_c[p*DATA_W +: DATA_W] = rdat;
      rs_tag_c[p*TAG_W +: TAG_W]    = rtag;
    end
  end

  assign bus.rs_valid = rs_valid_c;
  assign bus.rs_data  = rs_data_c;
  assign bus.rs_tag   = rs_tag_c;
  assign bus.busy_cnt = busy_q;

endmodule

// File: tb/tb_rename_regfile_mp.sv
// tb/tb_rename_regfile_mp.sv - scoreboard bench for rename_regfile_mp with directed vectors
module tb_rename_regfile_mp;
  localparam int IDX_W  = 5;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rename_regfile_mp_if #(.NUM_REGS(32), .DATA_W(32), .ROB_DEPTH(16),
                         .REN_LANES(2), .CMT_LANES(2), .RD_PORTS(4)) bus ();

  rename_regfile_mp #(.NUM_REGS(32), .DATA_W(32), .ROB_DEPTH(16),
                      .REN_LANES(2), .CMT_LANES(2), .RD_PORTS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int              cyc;
    bit              is_busy;
    int              port;
    int              idx;
    logic            v;
    logic [31:0]     d;
    logic [3:0]      t;
    logic [5:0]      b;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: every expectation is checked at the falling edge of the cycle it was issued in.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (e.is_busy) begin
        if (bus.busy_cnt !== e.b) begin
          failed++;
          $display("FAIL busy_cnt cyc=%0d got=%0d want=%0d", e.cyc, bus.busy_cnt, e.b);
        end
      end else begin
        if (bus.rs_valid[e.port] !== e.v ||
            bus.rs_data[e.port*DATA_W +: DATA_W] !== e.d ||
            bus.rs_tag[e.port*TAG_W +: TAG_W] !== e.t) begin
          failed++;
          $display("FAIL read cyc=%0d port=%0d x%0d got=(%b,%h,%0d) want=(%b,%h,%0d)",
                   e.cyc, e.port, e.idx, bus.rs_valid[e.port],
                   bus.rs_data[e.port*DATA_W +: DATA_W],
                   bus.rs_tag[e.port*TAG_W +: TAG_W], e.v, e.d, e.t);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.rename_en = '0;
    bus.commit_en = '0;
  endtask

  task automatic ren(input int l, input int rd, input int tg);
    bus.rename_en[l] = 1'b1;
    bus.rename_rd[l*IDX_W +: IDX_W]  = IDX_W'(rd);
    bus.rename_tag[l*TAG_W +: TAG_W] = TAG_W'(tg);
  endtask

  task automatic cmt(input int l, input int rd, input logic [31:0] val, input int tg);
    bus.commit_en[l] = 1'b1;
    bus.commit_rd[l*IDX_W +: IDX_W]    = IDX_W'(rd);
    bus.commit_val[l*DATA_W +: DATA_W] = val;
    bus.commit_tag[l*TAG_W +: TAG_W]   = TAG_W'(tg);
  endtask

  task automatic rd(input int p, input int idx, input logic v, input logic [31:0] d, input int t);
    exp_t e;
    bus.rs_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
    e.cyc = cyc; e.is_busy = 1'b0; e.port = p; e.idx = idx;
    e.v = v; e.d = d; e.t = TAG_W'(t); e.b = '0;
    exp_q.push_back(e);
  endtask

  task automatic bz(input int n);
    exp_t e;
    e.cyc = cyc; e.is_busy = 1'b1; e.port = 0; e.idx = 0;
    e.v = 1'b0; e.d = '0; e.t = '0; e.b = 6'(n);
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.flush = 1'b0; bus.rename_en = '0; bus.rename_rd = '0; bus.rename_tag = '0;
    bus.commit_en = '0; bus.commit_rd = '0; bus.commit_val = '0; bus.commit_tag = '0;
    bus.rs_idx = '0;
    // Held in reset: reads forced to (1,0,0).
    step(); rst = 1'b1;
    for (int p = 0; p < 4; p++) rd(p, 5, 1'b1, 32'h0, 0);
    bz(0);
    step(); rst = 1'b0;
    for (int p = 0; p < 4; p++) rd(p, 5, 1'b1, 32'h0, 0);
    bz(0);
    // x3 rename, then commit with bypass.
    step(); ren(0, 3, 7); rd(0, 3, 1'b1, 32'h0, 0);
    step(); rd(0, 3, 1'b0, 32'h0, 7); bz(1);
    step(); cmt(0, 3, 32'hDEAD_BEEF, 7); rd(0, 3, 1'b1, 32'hDEAD_BEEF, 7); rd(1, 5, 1'b1, 32'h0, 0); bz(1);
    step(); rd(0, 3, 1'b1, 32'hDEAD_BEEF, 7); bz(0);
    // x4 double rename, stale commit.
    step(); ren(0, 4, 2); ren(1, 4, 9); rd(1, 4, 1'b1, 32'h0, 0); bz(0);
    step(); cmt(0, 4, 32'h11, 2); rd(1, 4, 1'b0, 32'h0, 9); bz(1);
    step(); rd(1, 4, 1'b0, 32'h11, 9); bz(1);
    // x6 commit and rename in the same cycle.
    step(); ren(1, 6, 5); bz(1);
    step(); cmt(1, 6, 32'h66, 5); ren(0, 6, 12); rd(2, 6, 1'b1, 32'h66, 5); bz(2);
    step(); rd(2, 6, 1'b0, 32'h66, 12); bz(2);
    // x8 duplicate commit lanes.
    step(); ren(0, 8, 3); bz(2);
    step(); cmt(0, 8, 32'hA, 3); cmt(1, 8, 32'hB, 3); rd(3, 8, 1'b1, 32'hB, 3); bz(3);
    step(); rd(3, 8, 1'b1, 32'hB, 3); bz(2);
    // Flush with a commit and an ignored rename.
    step(); ren(0, 1, 1); ren(1, 2, 2); bz(2);
    step(); ren(0, 3, 4); rd(0, 1, 1'b0, 32'h0, 1); rd(1, 2, 1'b0, 32'h0, 2); bz(4);
    step(); bus.flush = 1'b1; cmt(0, 2, 32'h55, 2); ren(0, 9, 6);
    rd(0, 3, 1'b0, 32'hDEAD_BEEF, 4); rd(1, 2, 1'b1, 32'h55, 2); rd(2, 9, 1'b1, 32'h0, 0); bz(5);
    step(); rd(0, 3, 1'b1, 32'hDEAD_BEEF, 0); rd(1, 2, 1'b1, 32'h55, 0);
    rd(2, 9, 1'b1, 32'h0, 0); rd(3, 4, 1'b1, 32'h11, 0); bz(0);
    // x0 is immune to rename and commit.
    step(); ren(0, 0, 5); cmt(0, 0, 32'h99, 0); rd(0, 0, 1'b1, 32'h0, 0); bz(0);
    step(); rd(0, 0, 1'b1, 32'h0, 0); rd(1, 6, 1'b1, 32'h66, 0); bz(0);
    // Reset mid-run forces reads and busy_cnt.
    step(); ren(0, 7, 1); bz(0);
    step(); rst = 1'b1; rd(0, 7, 1'b1, 32'h0, 0); rd(1, 3, 1'b1, 32'h0, 0); bz(1);
    step(); rst = 1'b0; rd(0, 7, 1'b1, 32'h0, 0); rd(1, 3, 1'b1, 32'h0, 0); bz(0);
    step();
    step();
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
